// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address-split helper for the
// instruction-cache line-refill controller.
package icache_pkg;

  localparam int ICACHE_ADDR_W     = 32;
  localparam int ICACHE_DATA_W     = 32;
  localparam int ICACHE_RAM_ADDR_W = 10;
  localparam int ICACHE_LINE_WORDS = 8;
  localparam int ICACHE_OFFSET_W   = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_INDEX_W    = ICACHE_RAM_ADDR_W - ICACHE_OFFSET_W;
  localparam int ICACHE_TAG_W      = ICACHE_ADDR_W - 2 - ICACHE_OFFSET_W - ICACHE_INDEX_W;

  typedef enum logic [2:0] {
    ST_INVAL,
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_TAG
  } refill_state_t;

  // Field layout of a byte address with the default geometry, MSB first.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0]    tag;
    logic [ICACHE_INDEX_W-1:0]  index;
    logic [ICACHE_OFFSET_W-1:0] offset;
    logic [1:0]                 byte_sel;
  } addr_split_t;

  // Splits a byte address into tag / index / word offset / byte select.
  function automatic addr_split_t split_addr(input logic [ICACHE_ADDR_W-1:0] addr);
    return addr_split_t'(addr);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line-refill controller: takes a miss, issues one burst,
// writes the returning words into the data RAM and publishes the tag only
// once the whole line is in place. Sweeps every tag invalid after reset or
// on an invalidate request.
// Optional feature: define ICACHE_CRIT_WORD_FIRST_EN for a wrapping burst
// that starts at the missing word and forwards that word to fetch.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = ICACHE_ADDR_W,
  parameter int DATA_WIDTH     = ICACHE_DATA_W,
  parameter int RAM_ADDR_WIDTH = ICACHE_RAM_ADDR_W,
  parameter int LINE_WORDS     = ICACHE_LINE_WORDS,
  localparam int OFFSET_W      = $clog2(LINE_WORDS),
  localparam int INDEX_W       = RAM_ADDR_WIDTH - OFFSET_W,
  localparam int TAG_W         = ADDR_WIDTH - 2 - OFFSET_W - INDEX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_valid,
  input  logic [ADDR_WIDTH-1:0]     miss_addr,
  output logic                      miss_ready,
  input  logic                      inval,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  input  logic                      mem_rsp_err,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic                      tag_wr_en,
  output logic [INDEX_W-1:0]        tag_wr_index,
  output logic [TAG_W:0]            tag_wr_data,
  output logic                      crit_valid,
  output logic [DATA_WIDTH-1:0]     crit_data,
  output logic                      fill_done,
  output logic                      fill_err
);

  // One counter serves both the tag sweep (needs INDEX_W+1 bits) and the
  // beat count of a fill (needs OFFSET_W+1 bits); the index is never
  // narrower than the offset for any sensible geometry.
  localparam int CNT_W = INDEX_W + 1;
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'((1 << INDEX_W) - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(LINE_WORDS - 1);

  refill_state_t       state;
  logic [CNT_W-1:0]    cnt;
  logic                inval_pend;
  logic                miss_ready_q;
  logic                err;
  logic [TAG_W-1:0]    miss_tag;
  logic [INDEX_W-1:0]  miss_index;
  logic [OFFSET_W-1:0] beat_offset;
  logic                miss_fire;
  logic                beat_fire;

  // An invalidate in the same cycle wins over the miss, so it must also
  // withdraw ready combinationally to keep the handshake honest.
  assign miss_ready = miss_ready_q & ~inval;
  assign miss_fire  = miss_valid & miss_ready;
  assign beat_fire  = (state == ST_FILL) & mem_rsp_valid;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  logic [OFFSET_W-1:0] miss_offset;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];
  assign beat_offset      = miss_offset + cnt[OFFSET_W-1:0];

  // Remembers the missing word and forwards beat 0 alongside its RAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_offset <= '0;
      crit_valid  <= 1'b0;
      crit_data   <= '0;
    end else begin
      if (miss_fire) begin
        miss_offset <= miss_addr[2 +: OFFSET_W];
      end
      crit_valid <= beat_fire && (cnt == '0);
      if (beat_fire && (cnt == '0)) begin
        crit_data <= mem_rsp_data;
      end
    end
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFFSET_W+1:0];
  assign beat_offset      = cnt[OFFSET_W-1:0];
  assign crit_valid       = 1'b0;
  assign crit_data        = '0;
`endif

  // Main refill sequencer; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INVAL;
      cnt           <= '0;
      inval_pend    <= 1'b0;
      miss_ready_q  <= 1'b0;
      err           <= 1'b0;
      miss_tag      <= '0;
      miss_index    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      ram_wr_en     <= 1'b0;
      ram_wr_addr   <= '0;
      ram_wr_data   <= '0;
      tag_wr_en     <= 1'b0;
      tag_wr_index  <= '0;
      tag_wr_data   <= '0;
      fill_done     <= 1'b0;
      fill_err      <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      tag_wr_en <= 1'b0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;

      case (state)
        ST_INVAL: begin
          tag_wr_en    <= 1'b1;
          tag_wr_index <= cnt[INDEX_W-1:0];
          tag_wr_data  <= '0;
          cnt          <= cnt + 1'b1;
          if (cnt == SWEEP_LAST) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (inval || inval_pend) begin
            state        <= ST_INVAL;
            cnt          <= '0;
            inval_pend   <= 1'b0;
            miss_ready_q <= 1'b0;
          end else if (miss_fire) begin
            miss_tag      <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
            miss_index    <= miss_addr[OFFSET_W+2 +: INDEX_W];
            mem_req_valid <= 1'b1;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
            mem_req_addr  <= {miss_addr[ADDR_WIDTH-1:2], 2'b00};
`else
            mem_req_addr  <= {miss_addr[ADDR_WIDTH-1:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
`endif
            miss_ready_q  <= 1'b0;
            state         <= ST_REQ;
          end else begin
            miss_ready_q <= 1'b1;
          end
        end

        ST_REQ: begin
          if (inval) begin
            inval_pend <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            err           <= 1'b0;
            state         <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (inval) begin
            inval_pend <= 1'b1;
          end
          if (mem_rsp_valid) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= {miss_index, beat_offset};
            ram_wr_data <= mem_rsp_data;
            err         <= err | mem_rsp_err;
            cnt         <= cnt + 1'b1;
            if (cnt == BEAT_LAST) begin
              state <= ST_TAG;
            end
          end
        end

        ST_TAG: begin
          if (inval) begin
            inval_pend <= 1'b1;
          end
          tag_wr_en    <= 1'b1;
          tag_wr_index <= miss_index;
          tag_wr_data  <= err ? '0 : {1'b1, miss_tag};
          fill_done    <= ~err;
          fill_err     <= err;
          state        <= ST_IDLE;
        end

        default: begin
          state <= ST_INVAL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes the expected RAM
// writes, tag writes and burst requests into queues, and a negedge monitor
// pops and compares whenever the design presents one of them.
// Honours ICACHE_CRIT_WORD_FIRST_EN for the expected burst order.
module tb_icache_refill_ctrl;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        inval = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        tag_wr_en;
  logic [6:0]  tag_wr_index;
  logic [20:0] tag_wr_data;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        fill_done;
  logic        fill_err;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .inval         (inval),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .tag_wr_en     (tag_wr_en),
    .tag_wr_index  (tag_wr_index),
    .tag_wr_data   (tag_wr_data),
    .crit_valid    (crit_valid),
    .crit_data     (crit_data),
    .fill_done     (fill_done),
    .fill_err      (fill_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        crit;
    int          cyc;
  } ram_exp_t;

  typedef struct {
    logic [6:0]  idx;
    logic [20:0] data;
    logic        done;
    logic        err;
    int          cyc;
  } tag_exp_t;

  ram_exp_t    ram_q[$];
  tag_exp_t    tag_q[$];
  logic [31:0] req_q[$];

  int tests = 0;
  int fails = 0;
  int edge_cnt = -1;

  ram_exp_t    mon_ram;
  tag_exp_t    mon_tag;
  logic [31:0] mon_req;
  logic        req_active = 1'b0;
  logic [31:0] req_hold = '0;
  int          last_cyc;

  // Cycle k is the interval after the k-th rising edge following reset release.
  always @(posedge clk) edge_cnt <= rst ? -1 : edge_cnt + 1;

  // Guards against a hung design.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no completion, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM write, tag write and burst request
  // against the head of its expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      req_active = 1'b0;
    end else begin
      if (ram_wr_en) begin
        tests++;
        if (ram_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL ram_write: got unexpected write addr=0x%0h data=0x%0h, expected none", ram_wr_addr, ram_wr_data);
        end else begin
          mon_ram = ram_q.pop_front();
          if (ram_wr_addr !== mon_ram.addr || ram_wr_data !== mon_ram.data ||
              crit_valid !== mon_ram.crit || (mon_ram.crit && crit_data !== mon_ram.data) ||
              (mon_ram.cyc >= 0 && edge_cnt != mon_ram.cyc)) begin
            fails++;
            $display("[TB] FAIL ram_write: got addr=0x%0h data=0x%0h crit=%0b/0x%0h cyc=%0d, expected addr=0x%0h data=0x%0h crit=%0b cyc=%0d",
                     ram_wr_addr, ram_wr_data, crit_valid, crit_data, edge_cnt,
                     mon_ram.addr, mon_ram.data, mon_ram.crit, mon_ram.cyc);
          end
        end
      end else if (crit_valid) begin
        tests++;
        fails++;
        $display("[TB] FAIL crit_valid: got 1 without a RAM write, expected 0");
      end

      if (tag_wr_en) begin
        tests++;
        if (tag_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL tag_write: got unexpected write idx=0x%0h data=0x%0h, expected none", tag_wr_index, tag_wr_data);
        end else begin
          mon_tag = tag_q.pop_front();
          if (tag_wr_index !== mon_tag.idx || tag_wr_data !== mon_tag.data ||
              fill_done !== mon_tag.done || fill_err !== mon_tag.err ||
              (mon_tag.cyc >= 0 && edge_cnt != mon_tag.cyc)) begin
            fails++;
            $display("[TB] FAIL tag_write: got idx=0x%0h data=0x%0h done=%0b err=%0b cyc=%0d, expected idx=0x%0h data=0x%0h done=%0b err=%0b cyc=%0d",
                     tag_wr_index, tag_wr_data, fill_done, fill_err, edge_cnt,
                     mon_tag.idx, mon_tag.data, mon_tag.done, mon_tag.err, mon_tag.cyc);
          end
        end
      end else if (fill_done || fill_err) begin
        tests++;
        fails++;
        $display("[TB] FAIL fill_pulse: got done=%0b err=%0b without tag write, expected 0", fill_done, fill_err);
      end

      if (mem_req_valid) begin
        tests++;
        if (!req_active) begin
          if (req_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL mem_req: got unexpected request 0x%0h, expected none", mem_req_addr);
          end else begin
            mon_req = req_q.pop_front();
            if (mem_req_addr !== mon_req) begin
              fails++;
              $display("[TB] FAIL mem_req_addr: got 0x%0h expected 0x%0h", mem_req_addr, mon_req);
            end
          end
          req_active = 1'b1;
          req_hold   = mem_req_addr;
        end else if (mem_req_addr !== req_hold) begin
          fails++;
          $display("[TB] FAIL mem_req_stable: got 0x%0h expected 0x%0h", mem_req_addr, req_hold);
        end
        if (mem_req_ready) req_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int base_cyc);
    tag_exp_t t;
    for (int k = 0; k < 128; k++) begin
      t.idx  = 7'(k);
      t.data = '0;
      t.done = 1'b0;
      t.err  = 1'b0;
      t.cyc  = (base_cyc < 0) ? -1 : base_cyc + k;
      tag_q.push_back(t);
    end
  endtask

  task automatic wait_ready(input string name, input int exp_cyc);
    for (int i = 0; i < 400 && miss_ready !== 1'b1; i++) tick();
    if (miss_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: got miss_ready=%b after 400 cycles, expected 1", name, miss_ready);
    end else if (exp_cyc >= 0) begin
      check_output(name, 64'(edge_cnt), 64'(exp_cyc));
    end
  endtask

  // Issues one miss, handles the request handshake and returns beats,
  // pushing every expected response as it goes.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] exp_req,
                                input logic [6:0] exp_idx, input logic [19:0] exp_tag,
                                input logic [2:0] miss_off, input logic [31:0] data_base,
                                input int stall, input int gap, input int err_beat,
                                input int inval_beat, input int beats, output int last);
    ram_exp_t r;
    tag_exp_t t;
    logic [2:0] off;
    logic had_err;
    had_err = 1'b0;
    last = -1;
    req_q.push_back(exp_req);
    miss_valid = 1'b1;
    miss_addr  = addr;
    check_output("miss_ready_at_handshake", 64'(miss_ready), 64'd1);
    tick();
    miss_valid = 1'b0;
    miss_addr  = '0;
    check_output("req_valid_latency", 64'(mem_req_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      mem_rsp_valid = (s == 1);
      mem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      repeat (gap) tick();
      off    = CWF ? 3'(miss_off + 3'(i)) : 3'(i);
      r.addr = {exp_idx, off};
      r.data = 32'(data_base + 32'(i));
      r.crit = CWF && (i == 0);
      r.cyc  = edge_cnt + 1;
      ram_q.push_back(r);
      had_err = had_err | (i == err_beat);
      if (i == 7) begin
        t.idx  = exp_idx;
        t.data = had_err ? 21'd0 : {1'b1, exp_tag};
        t.done = ~had_err;
        t.err  = had_err;
        t.cyc  = edge_cnt + 2;
        tag_q.push_back(t);
        last = edge_cnt;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = r.data;
      mem_rsp_err   = (i == err_beat);
      inval         = (i == inval_beat);
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      inval         = 1'b0;
    end
  endtask

  initial begin
    // Reset state and the power-on sweep.
    repeat (3) tick();
    check_output("reset_miss_ready", 64'(miss_ready), 64'd0);
    check_output("reset_tag_wr_en", 64'(tag_wr_en), 64'd0);
    check_output("reset_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("reset_ram_wr_en", 64'(ram_wr_en), 64'd0);
    push_sweep(0);
    rst = 1'b0;
    wait_ready("ready_after_sweep", 128);

    // Clean fill of 0x0000_1234, back-to-back beats.
    apply_stimulus(32'h0000_1234, CWF ? 32'h0000_1234 : 32'h0000_1220, 7'h11, 20'h00001,
                   3'd5, 32'hA0, 0, 0, -1, -1, 8, last_cyc);
    wait_ready("ready_after_fill", last_cyc + 3);

    // Beat error on beat 3 with gaps between beats.
    apply_stimulus(32'h0004_5678, CWF ? 32'h0004_5678 : 32'h0004_5660, 7'h33, 20'h00045,
                   3'd6, 32'hB0, 0, 1, 3, -1, 8, last_cyc);
    wait_ready("ready_after_err_fill", last_cyc + 3);

    // Request stalled 5 cycles, stray beat in REQ, inval during FILL.
    apply_stimulus(32'h0000_1234, CWF ? 32'h0000_1234 : 32'h0000_1220, 7'h11, 20'h00001,
                   3'd5, 32'hC0, 5, 0, -1, 2, 8, last_cyc);
    push_sweep(-1);
    tick();
    tick();
    check_output("ready_held_by_pending_inval", 64'(miss_ready), 64'd0);
    wait_ready("ready_after_pending_sweep", -1);

    // Inval and miss in the same IDLE cycle: the miss is held off.
    push_sweep(-1);
    inval      = 1'b1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1234;
    #1;
    check_output("miss_ready_vs_inval", 64'(miss_ready), 64'd0);
    tick();
    inval      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    check_output("no_req_after_inval", 64'(mem_req_valid), 64'd0);
    wait_ready("ready_after_idle_sweep", -1);

    // Reset in the middle of a fill.
    apply_stimulus(32'h0000_1234, CWF ? 32'h0000_1234 : 32'h0000_1220, 7'h11, 20'h00001,
                   3'd5, 32'hD0, 0, 0, -1, -1, 3, last_cyc);
    tick();
    rst = 1'b1;
    tick();
    check_output("midfill_reset_ram_wr_en", 64'(ram_wr_en), 64'd0);
    check_output("midfill_reset_ram_wr_addr", 64'(ram_wr_addr), 64'd0);
    check_output("midfill_reset_tag_wr_en", 64'(tag_wr_en), 64'd0);
    check_output("midfill_reset_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("midfill_reset_miss_ready", 64'(miss_ready), 64'd0);
    check_output("midfill_reset_pulses", 64'({fill_done, fill_err, crit_valid}), 64'd0);
    push_sweep(0);
    rst = 1'b0;
    wait_ready("ready_after_midfill_reset", 128);

    // Everything expected must have been seen.
    check_output("ram_queue_drained", 64'(ram_q.size()), 64'd0);
    check_output("tag_queue_drained", 64'(tag_q.size()), 64'd0);
    check_output("req_queue_drained", 64'(req_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Line-refill controller for the instruction cache. It accepts a miss address from the fetch/lookup stage and issues one fixed-length burst to the memory side. Returned words are written into the 1024×32 simple dual-port data RAM through its write port. A valid tag is written only after the whole line has landed. After reset, or on request, it sweeps all tags invalid.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; equals the data RAM width.
- RAM_ADDR_WIDTH, 10, data RAM word-address width.
- LINE_WORDS, 8, words per line; power of two, at least 2.
- Derived widths:
  - OFFSET_W = log2(LINE_WORDS).
  - INDEX_W = RAM_ADDR_WIDTH − OFFSET_W.
  - TAG_W = ADDR_WIDTH − 2 − OFFSET_W − INDEX_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  miss request.
- miss_addr  in  ADDR_WIDTH  byte address of the missing fetch.
- miss_ready  out  1  miss accepted when valid && ready.
- inval  in  1  one-cycle pulse requesting a full invalidate.
- mem_req_valid  out  1  burst request.
- mem_req_addr  out  ADDR_WIDTH  burst start byte address.
- mem_req_ready  in  1  burst request accepted.
- mem_rsp_valid  in  1  one data beat.
- mem_rsp_data  in  DATA_WIDTH  beat data.
- mem_rsp_err  in  1  beat error.
- ram_wr_en  out  1  data RAM write enable.
- ram_wr_addr  out  RAM_ADDR_WIDTH  data RAM write address.
- ram_wr_data  out  DATA_WIDTH  data RAM write data.
- tag_wr_en  out  1  tag RAM write enable.
- tag_wr_index  out  INDEX_W  tag RAM write index.
- tag_wr_data  out  TAG_W+1  tag entry, {valid, tag}.
- crit_valid  out  1  critical word forwarded to fetch.
- crit_data  out  DATA_WIDTH  critical word.
- fill_done  out  1  one-cycle pulse: line filled without error.
- fill_err  out  1  one-cycle pulse: line filled with at least one beat error.

## Operation
- States: INVAL, IDLE, REQ, FILL, TAG.
- Reset:
  - All outputs are 0 while rst is high.
  - State becomes INVAL, counter 0, inval-pending flag cleared.
- INVAL:
  - Each cycle: tag_wr_en=1, tag_wr_index=counter, tag_wr_data=0; counter increments.
  - After index 2^INDEX_W−1 is written, go to IDLE.
- IDLE:
  - miss_ready=1 only in IDLE with no pending inval.
  - inval (or a pending inval) goes to INVAL and takes priority over a simultaneous miss_valid; in that case miss_ready=0 and the miss is not taken.
  - A miss handshake captures tag, index and offset, then goes to REQ.
- REQ:
  - mem_req_valid=1; mem_req_addr stays stable until mem_req_ready.
  - Handshake goes to FILL with beat counter 0 and error flag clear.
- FILL:
  - Each mem_rsp_valid beat i is registered and written the next cycle: ram_wr_en=1, ram_wr_addr={index, offset_i}, ram_wr_data=beat.
  - mem_rsp_err ORs into the error flag; the write still happens, and all LINE_WORDS beats are always consumed.
  - After beat LINE_WORDS−1 is accepted, go to TAG.
- TAG:
  - One cycle: tag_wr_en=1 with tag_wr_index=index.
  - tag_wr_data={~err, tag} on success; all zeros when err is set.
  - fill_done pulses if err is clear, fill_err pulses if err is set, then go to IDLE.
- inval arriving in REQ/FILL/TAG sets the pending flag; the sweep runs from IDLE, and the in-flight fill completes first.
- Offset arithmetic wraps modulo LINE_WORDS; the counter is OFFSET_W+1 bits wide in FILL and INDEX_W+1 bits wide in INVAL.

## Timing
- rst released before edge 0 → sweep writes index k at cycle k; miss_ready=1 first at cycle 2^INDEX_W (128 with defaults).
- Miss handshake at T → mem_req_valid at T+1.
- Beat accepted at B → RAM write at B+1.
- Last beat at L → RAM write at L+1, tag write plus done/err pulse at L+2, miss_ready=1 at L+3.
- The tag is never valid before the last data word is written.
- Gaps between beats are allowed. A beat arriving outside FILL is ignored.

## Configuration
- ICACHE_CRIT_WORD_FIRST_EN defined:
  - mem_req_addr = miss word address (wrapping burst).
  - offset_i = (miss_offset + i) mod LINE_WORDS.
  - crit_valid pulses with beat 0's RAM write cycle, and crit_data equals that word.
- Undefined:
  - mem_req_addr is line-aligned (low OFFSET_W+2 bits zero) and offset_i = i.
  - crit_valid and crit_data are tied to 0.

## Structure
- Package icache_pkg holds the LINE_WORDS/OFFSET_W/INDEX_W/TAG_W constants, the state enum and the address-split helper function.
- No sub-module: one counter is shared between the sweep and the fill, and the logic fits a single module of about 200 lines.

## Test plan
- Reset release → 128 consecutive tag writes, indices 0..127 with data 0; miss_ready rises at cycle 128.
- Miss 0x0000_1234 (index 0x11, offset 5, tag 0x00001), 8 beats 0xA0..0xA7 back-to-back:
  - Without the macro: request 0x0000_1220; writes to RAM addr 0x088..0x08F in order; tag {1, 0x00001} at L+2; fill_done.
- Same miss with ICACHE_CRIT_WORD_FIRST_EN:
  - Request 0x0000_1234.
  - Write addresses 0x08D, 0x08E, 0x08F, 0x088…0x08C.
  - crit_valid with 0xA0 on the first write.
- mem_rsp_err on beat 3 → all 8 writes still occur; tag written as 0; fill_err pulses; fill_done stays 0.
- inval pulse during FILL → fill completes with fill_done, then a 128-cycle sweep; a miss presented in the same cycle as an IDLE inval is held off (miss_ready=0).
- rst asserted mid-FILL → next cycle all outputs are 0 and a full sweep restarts; mem_req_ready held low for 5 cycles in REQ → mem_req_addr stays stable throughout.
